alu_op_sequencer: RTL and testbench

Command-side master for the 32-bit datapath ALU. It accepts one operation request (opcode plus two operands) over a valid/ready handshake and drives the ALU's enable, Control, A_bus and B_bus. It waits the ALU's fixed multi-cycle latency, then captures C_bus and Z_flag and returns the result over a valid/ready response channel. It sits between the instruction decode/control unit and the ALU.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu.sv | 47 ++++
 rtl/alu_lat_timer.sv | 22 ++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, data width, state encodings and compute helper
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] HOLD     = 4'd0;
  localparam logic [3:0] ADD      = 4'd1;
  localparam logic [3:0] SUB      = 4'd2;
  localparam logic [3:0] MUL      = 4'd3;
  localparam logic [3:0] MOD      = 4'd4;
  localparam logic [3:0] PASSATOC = 4'd5;
  localparam logic [3:0] PASSBTOC = 4'd6;
  localparam logic [3:0] INCAC    = 4'd7;
  localparam logic [3:0] DECAC    = 4'd8;
  localparam logic [3:0] RESET    = 4'd9;

  localparam logic [DATA_W-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;
  typedef enum logic [1:0] {ALU_IDLE, ALU_FETCH, ALU_EXEC, ALU_WRITE} alu_state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= ADD) && (op <= RESET);
  endfunction

  // Unknown codes (including HOLD) leave the result register unchanged.
  function automatic logic [DATA_W-1:0] alu_compute(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] r;
    r = c;
    case (op)
      ADD:      r = a + b;
      SUB:      r = a - b;
      MUL:      r = a * b;
      MOD:      r = (b == '0) ? a : a % b;
      PASSATOC: r = a;
      PASSBTOC: r = b;
      INCAC:    r = a + ONE;
      DECAC:    r = a - ONE;
      RESET:    r = '0;
      default:  r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit datapath ALU with a fixed 4-state evaluation cycle
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [3:0]        control,
  input  logic [DATA_W-1:0] a_bus,
  input  logic [DATA_W-1:0] b_bus,
  output logic [DATA_W-1:0] c_bus,
  output logic              z_flag
);

  alu_state_t state, next_state;
  logic [DATA_W-1:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ALU_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ALU_IDLE:  if (enable) next_state = ALU_FETCH;
      ALU_FETCH: next_state = ALU_EXEC;
      ALU_EXEC:  next_state = ALU_WRITE;
      ALU_WRITE: next_state = ALU_IDLE;
      default:   next_state = ALU_IDLE;
    endcase
  end

  assign result = alu_compute(control, a_bus, b_bus, c_bus);

  // Z_flag is inverted (0 means zero) and only refreshed by SUB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_bus  <= '0;
      z_flag <= 1'b1;
    end else if (state == ALU_WRITE) begin
      c_bus <= result;
      if (control == SUB) z_flag <= (result != '0);
    end
  end

endmodule

// File: rtl/alu_lat_timer.sv
// rtl/alu_lat_timer.sv - loadable down-counter with a done flag for multi-cycle units
module alu_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - single-op command master for the ALU; ALU_SEQ_OPCHK_EN enables opcode checking
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_zraw,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  op_count,
  output logic              alu_enable,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_z
);

  localparam int TW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_t state, next_state;
  logic accept;
  logic illegal;
  logic timer_done;

`ifdef ALU_SEQ_OPCHK_EN
  assign illegal = !op_legal(cmd_op);
`else
  assign illegal = 1'b0;
`endif

  assign accept = cmd_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    alu_enable = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = illegal ? RESP : ISSUE;
      end
      ISSUE: begin
        alu_enable = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (timer_done) next_state = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  alu_lat_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ISSUE),
    .load_val (TW'(ALU_LAT - 1)),
    .done     (timer_done)
  );

  // ALU inputs stay stable after issue: the ALU re-reads Control on every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= 4'b0000;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_zraw <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept && !illegal) begin
        alu_ctrl <= cmd_op;
        alu_a    <= cmd_a;
        alu_b    <= cmd_b;
      end
      if (accept && illegal) begin
        rsp_data <= '0;
        rsp_zero <= 1'b1;
        rsp_zraw <= 1'b0;
      end
      if (state == WAIT && timer_done) begin
        rsp_data <= alu_c;
        rsp_zraw <= alu_z;
        rsp_zero <= (alu_c == '0);
      end
      if (state == RESP && rsp_ready) op_count <= op_count + CNT_W'(1);
    end
  end

`ifdef ALU_SEQ_OPCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err <= 1'b0;
    else if (accept) rsp_err <= illegal;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench: sequencer driving the real ALU
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int LAT = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic rsp_zero, rsp_zraw, rsp_err;
  logic [CW-1:0] op_count;
  logic alu_enable;
  logic [3:0] alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_c;
  logic alu_z;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        zraw;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cnt = 0;
  int exp_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (alu_enable === 1'b1) en_cnt <= en_cnt + 1;

  alu_op_sequencer #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_zraw(rsp_zraw), .rsp_err(rsp_err), .op_count(op_count),
    .alu_enable(alu_enable), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_z(alu_z)
  );

  alu u_alu (
    .clk(clk), .rst_n(rst_n), .enable(alu_enable), .control(alu_ctrl),
    .a_bus(alu_a), .b_bus(alu_b), .c_bus(alu_c), .z_flag(alu_z)
  );

  // acc is the index of the accepting clock edge.
  task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input bit push, output int acc, output bit to);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    if (push) sb.push_back(e);
    to = 1'b1; acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready === 1'b1) begin
        acc = cyc + 1; to = 1'b0;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int vc, output bit to);
    to = 1'b1; vc = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) begin
        vc = cyc; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
  endtask

  task automatic transact(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic ez, input logic ezr,
                          output int lat, output bit to, output logic [31:0] d,
                          output logic z, output logic zr, output logic er);
    int acc, vc;
    bit t1, t2;
    exp_t e;
    e.data = ed; e.zero = ez; e.zraw = ezr;
    vc = 0;
    send_cmd(op, a, b, e, 1'b1, acc, t1);
    if (!t1) wait_valid(vc, t2);
    else t2 = 1'b1;
    to = t1 | t2;
    lat = vc - acc;
    d = rsp_data; z = rsp_zero; zr = rsp_zraw; er = rsp_err;
    if (!to) finish_rsp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready);
    end
    tests++;
    if ({rsp_valid, rsp_err, alu_enable, alu_ctrl, rsp_zero, rsp_zraw} !== 9'b0) begin
      fails++;
      $display("FAIL reset_flags got=%b want=0", {rsp_valid, rsp_err, alu_enable, alu_ctrl, rsp_zero, rsp_zraw});
    end
    tests++;
    if ({alu_a, alu_b, rsp_data, op_count} !== '0) begin
      fails++;
      $display("FAIL reset_data got a=%h b=%h d=%h cnt=%0d want all 0", alu_a, alu_b, rsp_data, op_count);
    end
  endtask

  task automatic test_add();
    int lat, en0; bit to; logic [31:0] d; logic z, zr, er; exp_t e;
    en0 = en_cnt;
    rsp_ready = 1'b1;
    transact(ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'bx, lat, to, d, z, zr, er);
    e = sb.pop_front();
    tests++;
    if (to) begin fails++; $display("FAIL add_timeout got=timeout want=response"); end
    tests++;
    if (lat != LAT + 1) begin fails++; $display("FAIL add_latency got=%0d want=%0d", lat, LAT + 1); end
    tests++;
    if (d !== e.data || z !== e.zero || er !== 1'b0) begin
      fails++; $display("FAIL add_result got=%0d/z%b/e%b want=%0d/z%b/e0", d, z, er, e.data, e.zero);
    end
    tests++;
    if (op_count !== exp_count[CW-1:0] || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL add_count got=%0d/v%b want=%0d/v0", op_count, rsp_valid, exp_count);
    end
    tests++;
    if (en_cnt - en0 != 1) begin fails++; $display("FAIL add_enable_pulses got=%0d want=1", en_cnt - en0); end
  endtask

  task automatic test_sub();
    int lat; bit to; logic [31:0] d; logic z, zr, er; exp_t e;
    transact(SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, lat, to, d, z, zr, er);
    e = sb.pop_front();
    tests++;
    if (to || d !== e.data || z !== e.zero || zr !== e.zraw) begin
      fails++; $display("FAIL sub_equal got=%0d/z%b/zr%b to%b want=%0d/z%b/zr%b", d, z, zr, to, e.data, e.zero, e.zraw);
    end
    transact(SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b1, lat, to, d, z, zr, er);
    e = sb.pop_front();
    tests++;
    if (to || d !== e.data || z !== e.zero || zr !== e.zraw) begin
      fails++; $display("FAIL sub_diff got=%0d/z%b/zr%b to%b want=%0d/z%b/zr%b", d, z, zr, to, e.data, e.zero, e.zraw);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2; bit to, got1, got2; exp_t e;
    got1 = 1'b0; got2 = 1'b0; a2 = 0;
    rsp_ready = 1'b1;
    send_cmd(MUL, 32'd6, 32'd7, '{32'd42, 1'b0, 1'bx}, 1'b1, a1, to);
    cmd_valid = 1'b1; cmd_op = MOD; cmd_a = 32'd65; cmd_b = 32'd30;
    sb.push_back('{32'd5, 1'b0, 1'bx});
    for (int i = 0; i < 40; i++) begin
      if (!got1 && rsp_valid === 1'b1) begin
        got1 = 1'b1; e = sb.pop_front();
        tests++;
        if (rsp_data !== e.data) begin fails++; $display("FAIL b2b_mul got=%0d want=%0d", rsp_data, e.data); end
      end
      if (cmd_ready === 1'b1 && got1) begin
        a2 = cyc + 1; got2 = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_count++;
    tests++;
    if (to || !got1 || !got2 || a2 - a1 < LAT + 3) begin
      fails++; $display("FAIL b2b_spacing got=%0d want>=%0d (to%b r%b a%b)", a2 - a1, LAT + 3, to, got1, got2);
    end
    wait_valid(a1, to);
    e = sb.pop_front();
    tests++;
    if (to || rsp_data !== e.data) begin fails++; $display("FAIL b2b_mod got=%0d to%b want=%0d", rsp_data, to, e.data); end
    if (!to) finish_rsp();
  endtask

  task automatic test_backpressure();
    int acc, vc; bit to, bad; exp_t e;
    bad = 1'b0;
    rsp_ready = 1'b0;
    send_cmd(PASSBTOC, 32'h1234, 32'hDEADBEEF, '{32'hDEADBEEF, 1'b0, 1'bx}, 1'b1, acc, to);
    wait_valid(vc, to);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_a = 32'hFFFF; cmd_b = 32'h1;
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || cmd_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    tests++;
    if (to || bad) begin fails++; $display("FAIL bp_hold got data=%h rdy=%b to%b want data=%h rdy=0", rsp_data, cmd_ready, to, e.data); end
    if (!to) finish_rsp();
    @(negedge clk);
    tests++;
    if (op_count !== exp_count[CW-1:0] || alu_b !== 32'hDEADBEEF) begin
      fails++; $display("FAIL bp_count got=%0d b=%h want=%0d b=deadbeef", op_count, alu_b, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    int acc, lat; bit to, seen; logic [31:0] d; logic z, zr, er; exp_t e;
    seen = 1'b0;
    send_cmd(ADD, 32'd3, 32'd4, '{32'd7, 1'b0, 1'bx}, 1'b0, acc, to);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (alu_enable !== 1'b0 || rsp_valid !== 1'b0 || op_count !== '0) begin
      fails++; $display("FAIL midreset_clear got en%b v%b cnt=%0d want en0 v0 cnt=0", alu_enable, rsp_valid, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen) begin fails++; $display("FAIL midreset_ghost got=response want=none"); end
    transact(ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'bx, lat, to, d, z, zr, er);
    e = sb.pop_front();
    tests++;
    if (to || d !== e.data || op_count !== exp_count[CW-1:0]) begin
      fails++; $display("FAIL midreset_next got=%0d cnt=%0d to%b want=%0d cnt=%0d", d, op_count, to, e.data, exp_count);
    end
  endtask

`ifdef ALU_SEQ_OPCHK_EN
  task automatic test_opchk();
    int lat, en0; bit to; logic [31:0] d; logic z, zr, er; exp_t e; logic [3:0] ctrl0;
    en0 = en_cnt; ctrl0 = alu_ctrl;
    transact(4'hC, 32'd11, 32'd22, 32'd0, 1'b1, 1'b0, lat, to, d, z, zr, er);
    e = sb.pop_front();
    tests++;
    if (to || er !== 1'b1 || d !== e.data || z !== e.zero || zr !== e.zraw || lat > 2) begin
      fails++; $display("FAIL opchk_rsp got e%b d=%0d z%b zr%b lat=%0d want e1 d=0 z1 zr0 lat<=2", er, d, z, zr, lat);
    end
    tests++;
    if (en_cnt != en0 || alu_ctrl !== ctrl0) begin
      fails++; $display("FAIL opchk_untouched got pulses=%0d ctrl=%h want 0 ctrl=%h", en_cnt - en0, alu_ctrl, ctrl0);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_SEQ_OPCHK_EN
    test_opchk();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
